mul_div_unit: RTL

Iterative multi-cycle multiply/divide engine for the multicycle MIPS datapath, executing MULT, MULTU, DIV and DIVU. It sits directly upstream of the HI/LO register pair. hi_out and lo_out feed the HI/LO register data inputs, and the single-cycle done pulse drives the HI/LO joint-write enable. The controller starts an operation and stalls on busy.

---
 rtl/mul_div_unit.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU engine feeding the HI/LO register pair
module mul_div_unit #(
    parameter int SIZE = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [SIZE-1:0] A,
    input  logic [SIZE-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] hi_out,
    output logic [SIZE-1:0] lo_out,
    output logic            div_by_zero
);

    localparam int CW = $clog2(SIZE) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE-1:0]   a_q, b_q, mag_q, hi_q, lo_q;
    logic [1:0]        op_q;
    logic [2*SIZE:0]   acc_q;
    logic [CW-1:0]     cnt_q;
    logic              neg_res_q, neg_rem_q, dbz_q;

    logic              a_neg, b_neg, is_dbz;
    logic [SIZE-1:0]   a_mag, b_mag, quo_fix, rem_fix;
    logic [SIZE:0]     mul_upper, div_sh;
    logic [SIZE+1:0]   div_diff;
    logic [2*SIZE:0]   mul_next, div_next;
    logic [2*SIZE-1:0] prod_fix;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // RUN holds one extra slot after the last iteration (cnt_q == SIZE) before FIX
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_PREP;
            S_PREP:  state_d = S_RUN;
            S_RUN:   if (cnt_q == CW'(SIZE)) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    always_comb begin
        a_neg = ~op_q[0] & a_q[SIZE-1];
        b_neg = ~op_q[0] & b_q[SIZE-1];
        a_mag = a_neg ? -a_q : a_q;
        b_mag = b_neg ? -b_q : b_q;

        mul_upper = acc_q[2*SIZE:SIZE] + {1'b0, (acc_q[0] ? mag_q : {SIZE{1'b0}})};
        mul_next  = {1'b0, mul_upper, acc_q[SIZE-1:1]};

        // Restoring step: remainder lives in acc_q[2*SIZE:SIZE], dividend/quotient below it
        div_sh   = {acc_q[2*SIZE-1:SIZE], acc_q[SIZE-1]};
        div_diff = {1'b0, div_sh} - {2'b00, mag_q};
        div_next = {(div_diff[SIZE+1] ? div_sh : div_diff[SIZE:0]),
                    acc_q[SIZE-2:0], ~div_diff[SIZE+1]};

        prod_fix = neg_res_q ? -acc_q[2*SIZE-1:0] : acc_q[2*SIZE-1:0];
        quo_fix  = neg_res_q ? -acc_q[SIZE-1:0] : acc_q[SIZE-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*SIZE-1:SIZE] : acc_q[2*SIZE-1:SIZE];
        is_dbz   = op_q[1] && (b_q == {SIZE{1'b0}});
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            mag_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= op;
                        dbz_q <= 1'b0;
                    end
                end
                S_PREP: begin
                    cnt_q     <= '0;
                    neg_res_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    if (op_q[1]) begin
                        mag_q <= b_mag;
                        acc_q <= {{(SIZE+1){1'b0}}, a_mag};
                    end else begin
                        mag_q <= a_mag;
                        acc_q <= {{(SIZE+1){1'b0}}, b_mag};
                    end
                end
                S_RUN: begin
                    if (cnt_q != CW'(SIZE)) begin
                        acc_q <= op_q[1] ? div_next : mul_next;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_FIX: begin
                    if (is_dbz) begin
                        hi_q  <= a_q;
                        lo_q  <= {SIZE{1'b1}};
                        dbz_q <= 1'b1;
                    end else if (op_q[1]) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*SIZE-1:SIZE];
                        lo_q <= prod_fix[SIZE-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi_out      = hi_q;
    assign lo_out      = lo_q;
    assign div_by_zero = dbz_q;

endmodule
